// File: rtl/gsim_pkg.sv
// rtl/gsim_pkg.sv - shared states, stencil coefficients and saturation helper for the Gauss-Seidel solver
package gsim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Row stencil: 20*x_i - 13(x_{i+-1}) + 6(x_{i+-2}) - (x_{i+-3}) = b_i
    localparam int COEF_C1 = 13;
    localparam int COEF_C2 = 6;
    localparam int COEF_C3 = 1;
    localparam int COEF_D  = 20;

    // Clamp a wide signed value to the signed range of a w-bit word
    function automatic logic signed [63:0] sat_x(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/gsim_div20.sv
// rtl/gsim_div20.sv - combinational floor division of a signed value by 20
module gsim_div20
    import gsim_pkg::*;
#(
    parameter int W = 38
) (
    input  logic signed [W-1:0] num,
    output logic signed [W-1:0] quo
);

    localparam logic signed [W-1:0] DIV = W'(COEF_D);

    logic signed [W-1:0] q_trunc;
    logic signed [W-1:0] r_trunc;

    // Native division truncates toward zero; step down one when a negative value leaves a remainder
    assign q_trunc = num / DIV;
    assign r_trunc = num % DIV;
    assign quo     = (r_trunc != '0 && num[W-1]) ? q_trunc - W'(1) : q_trunc;

endmodule

// File: rtl/gsim_param_solver.sv
// rtl/gsim_param_solver.sv - banded Gauss-Seidel solver with load, sweep and backpressured result stream
module gsim_param_solver
    import gsim_pkg::*;
#(
    parameter int N      = 16,
    parameter int B_W    = 16,
    parameter int X_W    = 32,
    parameter int FRAC   = 16,
    parameter int ITER_W = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_en,
    input  logic signed [B_W-1:0]  b_in,
    input  logic [ITER_W-1:0]      iter_max,
    input  logic signed [X_W-1:0]  tol,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [X_W-1:0]  x_out,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   converged,
    output logic [ITER_W-1:0]      iter_count
);

    localparam int IW = $clog2(N);
    localparam int SW = X_W + 6;

    state_t                 state;
    logic [IW-1:0]          row;
    logic [ITER_W-1:0]      iter_max_r;
    logic signed [X_W-1:0]  tol_r;
    logic [X_W:0]           maxdelta;
    logic signed [X_W-1:0]  x_mem [N];
    logic signed [B_W-1:0]  b_mem [N];

    logic signed [X_W-1:0]  nb [7];
    logic signed [X_W-1:0]  x_nxt;
    logic signed [SW-1:0]   s_sum;
    logic signed [SW-1:0]   q_div;
    logic signed [X_W-1:0]  x_new;
    logic signed [X_W:0]    dif;
    logic [X_W:0]           absd;
    logic [X_W:0]           md_new;
    logic                   conv;
    logic [ITER_W-1:0]      iter_next;

    // Neighbour window x_{row-3..row+3} with zero fill, plus the next row for the output stream
    always_comb begin
        for (int k = 0; k < 7; k++) nb[k] = '0;
        x_nxt = '0;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < 7; k++) begin
                if (int'(row) + k - 3 == j) nb[k] = x_mem[j];
            end
            if (int'(out_idx) + 1 == j) x_nxt = x_mem[j];
        end
    end

    // Row update numerator and delta tracking; widths leave headroom so the sum never wraps
    always_comb begin
        s_sum = (SW'(b_mem[row]) <<< FRAC)
              + SW'(COEF_C1) * (SW'(nb[2]) + SW'(nb[4]))
              - SW'(COEF_C2) * (SW'(nb[1]) + SW'(nb[5]))
              + SW'(COEF_C3) * (SW'(nb[0]) + SW'(nb[6]));
        x_new     = X_W'(sat_x(64'(q_div), X_W));
        dif       = (X_W+1)'(x_new) - (X_W+1)'(nb[3]);
        absd      = dif[X_W] ? $unsigned(-dif) : $unsigned(dif);
        md_new    = (absd > maxdelta) ? absd : maxdelta;
        conv      = $signed({1'b0, md_new}) < $signed({{2{tol_r[X_W-1]}}, tol_r});
        iter_next = iter_count + ITER_W'(1);
    end

    gsim_div20 #(.W(SW)) u_div20 (
        .num (s_sum),
        .quo (q_div)
    );

    // Control FSM: load b, sweep rows in place, then stream x with handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            row        <= '0;
            iter_max_r <= '0;
            tol_r      <= '0;
            maxdelta   <= '0;
            out_valid  <= 1'b0;
            x_out      <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            converged  <= 1'b0;
            iter_count <= '0;
            for (int i = 0; i < N; i++) begin
                x_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_en) begin
                        b_mem[0]   <= b_in;
                        row        <= IW'(1);
                        iter_max_r <= iter_max;
                        tol_r      <= tol;
                        converged  <= 1'b0;
                        iter_count <= '0;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_en) begin
                        b_mem[row] <= b_in;
                        if (row == IW'(N-1)) begin
                            for (int i = 0; i < N; i++) x_mem[i] <= '0;
                            row      <= '0;
                            maxdelta <= '0;
                            if (iter_max_r == '0) begin
                                state     <= OUT;
                                out_valid <= 1'b1;
                                x_out     <= '0;
                                out_idx   <= '0;
                                out_last  <= 1'b0;
                            end else begin
                                state <= SWEEP;
                            end
                        end else begin
                            row <= row + IW'(1);
                        end
                    end
                end
                SWEEP: begin
                    x_mem[row] <= x_new;
                    if (row == IW'(N-1)) begin
                        iter_count <= iter_next;
                        row        <= '0;
                        maxdelta   <= '0;
                        if (conv || iter_next == iter_max_r) begin
                            converged <= conv;
                            state     <= OUT;
                            out_valid <= 1'b1;
                            x_out     <= x_mem[0];
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                        end
                    end else begin
                        row      <= row + IW'(1);
                        maxdelta <= md_new;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_idx  <= out_idx + IW'(1);
                            x_out    <= x_nxt;
                            out_last <= (out_idx == IW'(N-2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
